pipe_drain_fifo: RTL and testbench

- Read-side counterpart to the fixed-latency delay/CORDIC pipelines: drains a non-stallable pipeline output into an elastic FIFO and presents it downstream with valid/ready backpressure.
- Issues credits to the pipeline launch side, so no sample is launched unless a FIFO slot is guaranteed when it emerges LATENCY cycles later.
- Sits at the pipeline tail; the launch logic gates on issue_ok.

---
 rtl/pipe_drain_pkg.sv | 17 +
 rtl/pipe_credit_ctr.sv | 39 +++
 rtl/pipe_drain_fifo.sv | 101 ++++++++++
 tb/tb_pipe_drain_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_drain_pkg.sv
// Shared constants, width helper and credit counter type for the pipeline drain FIFO.
package pipe_drain_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned DEPTH_DEF   = 32;
  localparam int unsigned LATENCY_DEF = 24;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  typedef logic [clog2(DEPTH_DEF):0] credit_t;

endpackage

// File: rtl/pipe_credit_ctr.sv
// Launch credit pool: one credit per FIFO slot, spent on issue, returned on pop.
module pipe_credit_ctr
  import pipe_drain_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  input  logic ret,
  output logic issue_ok,
  output logic credit_err
);

  localparam int unsigned CW = clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] credits;
  logic          take;

  assign issue_ok = (credits != '0);
  assign take     = issue & issue_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits    <= FULL;
      credit_err <= 1'b0;
    end else begin
      // Returns without a matching issue (e.g. stale samples after reset) saturate at DEPTH
      if (take && !ret)
        credits <= credits - 1'b1;
      else if (ret && !take && credits != FULL)
        credits <= credits + 1'b1;
      if (issue && !issue_ok)
        credit_err <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_drain_fifo.sv
// Credit-gated elastic FIFO at a non-stallable pipeline tail.
// Optional PIPE_DRAIN_STATS_EN adds stall_cycles and max_count outputs.
module pipe_drain_fifo
  import pipe_drain_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue,
  output logic                    issue_ok,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow,
  output logic                    credit_err
`ifdef PIPE_DRAIN_STATS_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [clog2(DEPTH):0]   max_count
`endif
);

  localparam int unsigned AW = clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LATENCY == 0) begin : g_bad_cfg
    $error("pipe_drain_fifo: DEPTH must be a power of two >= 2 and LATENCY nonzero");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty     = (wr_ptr == rd_ptr);
  // Full is judged pre-edge: a simultaneous pop does not make room for this push
  assign push      = in_valid & ~full;
  assign pop       = ~empty & out_ready;
  assign out_valid = ~empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (in_valid && full)
        overflow <= 1'b1;
    end
  end

  pipe_credit_ctr #(
    .DEPTH (DEPTH)
  ) u_credit (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .ret        (pop),
    .issue_ok   (issue_ok),
    .credit_err (credit_err)
  );

`ifdef PIPE_DRAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      max_count    <= '0;
    end else begin
      if (issue && !issue_ok && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (count > max_count)
        max_count <= count;
    end
  end
`else
  // stats counters absent in this build
`endif

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// Scoreboard bench for pipe_drain_fifo: models the pipeline delay line, credits and occupancy.
module tb_pipe_drain_fifo;
  import pipe_drain_pkg::*;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LAT   = 24;

  logic          clk = 1'b0;
  logic          rst_n, issue, issue_ok, in_valid, out_valid, out_ready;
  logic          overflow, credit_err;
  logic [DW-1:0] in_data, out_data;
  logic [5:0]    count;
`ifdef PIPE_DRAIN_STATS_EN
  logic [31:0]   stall_cycles;
  logic [5:0]    max_count;
  int unsigned   stall_m, max_m;
`endif

  always #5 clk = ~clk;

  pipe_drain_fifo #(
    .DEPTH   (DEPTH),
    .DATA_W  (DW),
    .LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue        (issue),
    .issue_ok     (issue_ok),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .overflow     (overflow),
    .credit_err   (credit_err)
`ifdef PIPE_DRAIN_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .max_count    (max_count)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] q[$];
  credit_t     cred_m;
  int unsigned cnt_m;
  logic        ovf_m, cerr_m;
  logic        pv [LAT];
  logic [31:0] pd [LAT];
  logic        frc_v;
  logic [31:0] frc_d, launch_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pipe_busy();
    for (int i = 0; i < int'(LAT); i++)
      if (pv[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive pipeline tail, compare registered outputs, advance model across the edge
  task automatic step();
    logic launch, push, pop;
    in_valid = pv[LAT-1] | frc_v;
    in_data  = frc_v ? frc_d : pd[LAT-1];
    check("count", count, cnt_m);
    check("out_valid", out_valid, cnt_m != 0);
    check("issue_ok", issue_ok, cred_m != 0);
    check("credits", dut.u_credit.credits, cred_m);
    check("overflow", overflow, ovf_m);
    check("credit_err", credit_err, cerr_m);
    check("count_bound", count <= DEPTH, 1);
    if (q.size() != 0) check("head", out_data, q[0]);
    launch = rst_n && issue && cred_m != 0;
    push   = in_valid && cnt_m != DEPTH;
    pop    = cnt_m != 0 && out_ready;
    if (!rst_n) begin
      cnt_m  = 0;
      cred_m = credit_t'(DEPTH);
      ovf_m  = 1'b0;
      cerr_m = 1'b0;
      q.delete();
`ifdef PIPE_DRAIN_STATS_EN
      stall_m = 0;
      max_m   = 0;
`endif
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(in_data);
      if (in_valid && cnt_m == DEPTH) ovf_m = 1'b1;
      if (push && !pop) cnt_m++;
      else if (pop && !push) cnt_m--;
`ifdef PIPE_DRAIN_STATS_EN
      if (issue && cred_m == 0) stall_m++;
      if (cnt_m > max_m) max_m = cnt_m;
`endif
      if (issue && cred_m == 0) cerr_m = 1'b1;
      if (launch && !pop) cred_m--;
      else if (pop && !launch && cred_m != credit_t'(DEPTH)) cred_m++;
    end
    @(posedge clk);
    #1;
    for (int i = int'(LAT) - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = launch;
    pd[0] = launch_d;
    if (launch) launch_d++;
    frc_v = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 300 && (cnt_m != 0 || pipe_busy()); i++) step();
    step();
    check("drain_count", count, 0);
    out_ready = 1'b0;
  endtask

  task automatic force_push(input logic [31:0] d);
    frc_v = 1'b1;
    frc_d = d;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; issue = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    frc_v = 1'b0; frc_d = '0; launch_d = 32'h1000;
    for (int i = 0; i < int'(LAT); i++) begin pv[i] = 1'b0; pd[i] = '0; end
    cnt_m = 0; cred_m = credit_t'(DEPTH); ovf_m = 1'b0; cerr_m = 1'b0;
`ifdef PIPE_DRAIN_STATS_EN
    stall_m = 0; max_m = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step();
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_issue_ok", issue_ok, 1);
    check("rst_credits", dut.u_credit.credits, 32);

    // single sample through the pipeline
    launch_d = 32'hDEADBEEF;
    issue = 1'b1;
    step();
    issue = 1'b0;
    launch_d = 32'h1000;
    repeat (25) step();
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 32'hDEADBEEF);
    check("single_count", count, 1);
    check("single_credits", dut.u_credit.credits, 31);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_pop_count", count, 0);
    check("single_pop_credits", dut.u_credit.credits, 32);

    // credit exhaustion
    issue = 1'b1;
    repeat (32) step();
    check("exh_issue_ok", issue_ok, 0);
    step();
    issue = 1'b0;
    check("exh_cerr", credit_err, 1);
    check("exh_credits", dut.u_credit.credits, 0);
    repeat (30) step();
    check("exh_count", count, 32);
    check("exh_ovf", overflow, 0);
    drain();

    // forced overflow bypassing credits
    for (int v = 0; v <= 32; v++) force_push(v);
    check("fovf_flag", overflow, 1);
    check("fovf_count", count, 32);
    check("fovf_head", out_data, 0);
    drain();

    // full with simultaneous push and pop
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int v = 0; v < 32; v++) force_push(32'h200 + v);
    check("fpp_pre_ovf", overflow, 0);
    check("fpp_pre_count", count, 32);
    out_ready = 1'b1;
    force_push(32'hBAD);
    out_ready = 1'b0;
    check("fpp_ovf", overflow, 1);
    check("fpp_count", count, 31);
    check("fpp_head", out_data, 32'h201);
    drain();

    // 100-sample stream with toggling ready, then reset mid-stream
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    launch_d = 32'h5000;
    for (int i = 0; i < 1000 && launch_d != 32'h5000 + 100; i++) begin
      issue = 1'b1;
      out_ready = (i % 2) != 0;
      step();
    end
    issue = 1'b0;
    check("stream_launched", launch_d, 32'h5000 + 100);
    repeat (10) begin
      out_ready = ~out_ready;
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_credits", dut.u_credit.credits, 32);
    drain();

`ifdef PIPE_DRAIN_STATS_EN
    check("stall_cycles", stall_cycles, stall_m);
    check("max_count", max_count, max_m);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
